dds_tune_ctrl: RTL and testbench

DDS_TUNE_CTRL -- requirements
Module: dds_tune_ctrl

---
 rtl/dds_pkg.sv | 10 +
 rtl/dds_dwell_cnt.sv | 27 ++
 rtl/dds_tune_ctrl.sv | 143 ++++++++++++++
 tb/tb_dds_tune_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths and FSM state encoding for the DDS tuning controller.
package dds_pkg;
    localparam int N_DEF  = 32;
    localparam int P_DEF  = 12;
    localparam int DW_DEF = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SW_APPLY = 2'd1;
    localparam logic [1:0] ST_SW_DWELL = 2'd2;
endpackage

// File: rtl/dds_dwell_cnt.sv
// Dwell down-counter: load a count, decrement to zero, flag the last clock.
module dds_dwell_cnt
    import dds_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expire
);
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - DW'(1);
        end
    end

    // A load of zero never expires; the caller handles single-clock dwells itself.
    assign expire = (cnt == DW'(1));
endmodule

// File: rtl/dds_tune_ctrl.sv
// DDS tuning controller: phase-continuous host retunes plus a stepped frequency sweep.
module dds_tune_ctrl
    import dds_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int P  = P_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrap,
    input  logic          host_req,
    input  logic [N-1:0]  host_fword,
    input  logic [P-1:0]  host_pword,
    output logic          host_ack,
    input  logic          sweep_start,
    input  logic          sweep_abort,
    input  logic [N-1:0]  sweep_f0,
    input  logic [N-1:0]  sweep_step,
    input  logic [DW-1:0] sweep_count,
    input  logic [DW-1:0] sweep_dwell,
    output logic [N-1:0]  fword,
    output logic [P-1:0]  pword,
    output logic          busy,
    output logic          sweep_done
);
    logic [1:0]    state;
    logic          host_pend;
    logic [N-1:0]  pend_fword;
    logic [P-1:0]  pend_pword;
    logic [N-1:0]  acc;
    logic [N-1:0]  step_q;
    logic [DW-1:0] count_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] k;
    logic [DW-1:0] cnt_load_val;
    logic          upd;
    logic          host_apply;
    logic          sweep_apply;
    logic          dwell_end;
    logic          last_step;
    logic          cnt_expire;

    // A stopped DDS (fword=0) never wraps, so treat every cycle as an update point.
    assign upd         = wrap || (fword == '0);
    assign host_apply  = upd && host_pend;
    assign sweep_apply = upd && !host_pend && !sweep_abort && (state == ST_SW_APPLY);
    assign last_step   = (k == count_q - DW'(1));

    // The update cycle is the first dwell clock, so the counter covers the rest.
    assign cnt_load_val = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
    assign dwell_end    = (sweep_apply && (dwell_q <= DW'(1))) ||
                          ((state == ST_SW_DWELL) && cnt_expire && !sweep_abort);
    assign busy         = (state != ST_IDLE) || host_pend;

    dds_dwell_cnt #(.DW(DW)) u_dwell_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sweep_apply),
        .load_val (cnt_load_val),
        .expire   (cnt_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_pend  <= 1'b0;
            pend_fword <= '0;
            pend_pword <= '0;
        end else if (!host_pend && host_req) begin
            host_pend  <= 1'b1;
            pend_fword <= host_fword;
            pend_pword <= host_pword;
        end else if (host_apply) begin
            host_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword    <= '0;
            pword    <= '0;
            host_ack <= 1'b0;
        end else begin
            host_ack <= host_apply;
            if (host_apply) begin
                fword <= pend_fword;
                pword <= pend_pword;
            end else if (sweep_apply) begin
                fword <= acc;
            end
        end
    end

    // acc always holds the frequency of the next step to apply (f0 + k*step).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            step_q     <= '0;
            count_q    <= '0;
            dwell_q    <= '0;
            k          <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (sweep_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sweep_start) begin
                            if (sweep_count == '0) begin
                                sweep_done <= 1'b1;
                            end else begin
                                acc     <= sweep_f0;
                                step_q  <= sweep_step;
                                count_q <= sweep_count;
                                dwell_q <= sweep_dwell;
                                k       <= '0;
                                state   <= ST_SW_APPLY;
                            end
                        end
                    end
                    ST_SW_APPLY, ST_SW_DWELL: begin
                        if (dwell_end) begin
                            if (last_step) begin
                                sweep_done <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                k     <= k + DW'(1);
                                acc   <= acc + step_q;
                                state <= ST_SW_APPLY;
                            end
                        end else if (sweep_apply) begin
                            state <= ST_SW_DWELL;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Scoreboard bench for dds_tune_ctrl: stimulus queues expected output events,
// a negedge monitor compares every output change/pulse against the queue head.
module tb_dds_tune_ctrl;
    logic        clk;
    logic        rst_n;
    logic        wrap;
    logic        host_req;
    logic [31:0] host_fword;
    logic [11:0] host_pword;
    logic        host_ack;
    logic        sweep_start;
    logic        sweep_abort;
    logic [31:0] sweep_f0;
    logic [31:0] sweep_step;
    logic [15:0] sweep_count;
    logic [15:0] sweep_dwell;
    logic [31:0] fword;
    logic [11:0] pword;
    logic        busy;
    logic        sweep_done;

    typedef struct {
        int          cyc;
        logic [31:0] f;
        logic [11:0] p;
        logic        ack;
        logic        done;
        logic        bsy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    exp_t        left_e;
    int          cyc;
    int          pass_cnt;
    int          total_cnt;
    int          c;
    logic [31:0] prev_f;
    logic [11:0] prev_p;

    dds_tune_ctrl #(.N(32), .P(12), .DW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wrap        (wrap),
        .host_req    (host_req),
        .host_fword  (host_fword),
        .host_pword  (host_pword),
        .host_ack    (host_ack),
        .sweep_start (sweep_start),
        .sweep_abort (sweep_abort),
        .sweep_f0    (sweep_f0),
        .sweep_step  (sweep_step),
        .sweep_count (sweep_count),
        .sweep_dwell (sweep_dwell),
        .fword       (fword),
        .pword       (pword),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_f = fword;
            prev_p = pword;
        end else begin
            if (fword !== prev_f || pword !== prev_p || host_ack || sweep_done) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL unexpected_event: got cyc=%0d f=%h p=%h ack=%b done=%b busy=%b, want no event",
                             cyc, fword, pword, host_ack, sweep_done, busy);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc == cyc && mon_e.f === fword && mon_e.p === pword &&
                        mon_e.ack === host_ack && mon_e.done === sweep_done && mon_e.bsy === busy) begin
                        pass_cnt++;
                    end else begin
                        $display("[TB] FAIL event: got cyc=%0d f=%h p=%h ack=%b done=%b busy=%b, want cyc=%0d f=%h p=%h ack=%b done=%b busy=%b",
                                 cyc, fword, pword, host_ack, sweep_done, busy,
                                 mon_e.cyc, mon_e.f, mon_e.p, mon_e.ack, mon_e.done, mon_e.bsy);
                    end
                end
            end
            prev_f = fword;
            prev_p = pword;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_event(input int ec, input logic [31:0] ef, input logic [11:0] ep,
                                input logic eack, input logic edone, input logic ebusy);
        exp_t e;
        e.cyc  = ec;
        e.f    = ef;
        e.p    = ep;
        e.ack  = eack;
        e.done = edone;
        e.bsy  = ebusy;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    endtask

    task automatic start_sweep(input logic [31:0] f0, input logic [31:0] step,
                               input logic [15:0] cnt, input logic [15:0] dwell);
        sweep_start = 1'b1;
        sweep_f0    = f0;
        sweep_step  = step;
        sweep_count = cnt;
        sweep_dwell = dwell;
    endtask

    initial begin
        cyc = 0; pass_cnt = 0; total_cnt = 0;
        rst_n = 1'b1; wrap = 1'b0; host_req = 1'b0; host_fword = '0; host_pword = '0;
        sweep_start = 1'b0; sweep_abort = 1'b0; sweep_f0 = '0; sweep_step = '0;
        sweep_count = '0; sweep_dwell = '0;
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_fword", fword, 32'h0);
        check_output("reset_pword", {20'h0, pword}, 32'h0);
        check_output("reset_ack", {31'h0, host_ack}, 32'h0);
        check_output("reset_done", {31'h0, sweep_done}, 32'h0);
        check_output("reset_busy", {31'h0, busy}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Host retune from a stopped DDS: applies on the cycle after latching.
        c = cyc;
        host_req = 1'b1; host_fword = 32'h0010_0000; host_pword = 12'h800;
        expect_event(c + 2, 32'h0010_0000, 12'h800, 1'b1, 1'b0, 1'b0);
        tick(1); host_req = 1'b0;
        tick(4);

        // Host retune while running: waits for the wrap seven cycles later.
        c = cyc;
        host_req = 1'b1; host_fword = 32'h1234_5678; host_pword = 12'h123;
        expect_event(c + 8, 32'h1234_5678, 12'h123, 1'b1, 1'b0, 1'b0);
        tick(1); host_req = 1'b0;
        tick(6); wrap = 1'b1;
        tick(1); wrap = 1'b0;
        tick(3);

        // Three-step sweep with wrap every cycle; inputs scrambled after start.
        c = cyc;
        wrap = 1'b1;
        start_sweep(32'd1000, 32'd500, 16'd3, 16'd4);
        expect_event(c + 2,  32'd1000, 12'h123, 1'b0, 1'b0, 1'b1);
        expect_event(c + 6,  32'd1500, 12'h123, 1'b0, 1'b0, 1'b1);
        expect_event(c + 10, 32'd2000, 12'h123, 1'b0, 1'b0, 1'b1);
        expect_event(c + 13, 32'd2000, 12'h123, 1'b0, 1'b1, 1'b0);
        tick(1); sweep_start = 1'b0;
        sweep_f0 = 32'd9; sweep_step = 32'd9; sweep_count = 16'd9; sweep_dwell = 16'd9;
        tick(15);

        // Host and sweep step both due on the same wrap: host first.
        c = cyc;
        wrap = 1'b0;
        start_sweep(32'd5000, 32'd100, 16'd2, 16'd2);
        host_req = 1'b1; host_fword = 32'h00AB_CDEF; host_pword = 12'h456;
        expect_event(c + 4,  32'h00AB_CDEF, 12'h456, 1'b1, 1'b0, 1'b1);
        expect_event(c + 5,  32'd5000, 12'h456, 1'b0, 1'b0, 1'b1);
        expect_event(c + 9,  32'd5100, 12'h456, 1'b0, 1'b0, 1'b1);
        expect_event(c + 10, 32'd5100, 12'h456, 1'b0, 1'b1, 1'b0);
        tick(1); sweep_start = 1'b0; host_req = 1'b0;
        tick(2); wrap = 1'b1;
        tick(2); wrap = 1'b0;
        tick(3); wrap = 1'b1;
        tick(1); wrap = 1'b0;
        tick(3);

        // Abort during the dwell of the second step.
        c = cyc;
        wrap = 1'b1;
        start_sweep(32'd100, 32'd10, 16'd5, 16'd6);
        expect_event(c + 2, 32'd100, 12'h456, 1'b0, 1'b0, 1'b1);
        expect_event(c + 8, 32'd110, 12'h456, 1'b0, 1'b0, 1'b1);
        tick(1); sweep_start = 1'b0;
        tick(9); sweep_abort = 1'b1;
        tick(1); sweep_abort = 1'b0;
        tick(1);
        check_output("abort_busy", {31'h0, busy}, 32'h0);
        check_output("abort_fword", fword, 32'd110);
        tick(10);

        // Zero-step sweep: immediate done, outputs untouched.
        c = cyc;
        start_sweep(32'd7, 32'd7, 16'd0, 16'd3);
        expect_event(c + 1, 32'd110, 12'h456, 1'b0, 1'b1, 1'b0);
        tick(1); sweep_start = 1'b0;
        tick(3);

        // Abort together with start keeps the block idle.
        start_sweep(32'd1, 32'd1, 16'd3, 16'd3);
        sweep_abort = 1'b1;
        tick(1); sweep_start = 1'b0; sweep_abort = 1'b0;
        tick(3);
        check_output("abort_start_busy", {31'h0, busy}, 32'h0);
        check_output("abort_start_fword", fword, 32'd110);

        // Step of all-ones wraps modulo 2^32; zero dwell means one clock.
        c = cyc;
        start_sweep(32'd0, 32'hFFFF_FFFF, 16'd3, 16'd0);
        expect_event(c + 2, 32'h0000_0000, 12'h456, 1'b0, 1'b0, 1'b1);
        expect_event(c + 3, 32'hFFFF_FFFF, 12'h456, 1'b0, 1'b0, 1'b1);
        expect_event(c + 4, 32'hFFFF_FFFE, 12'h456, 1'b0, 1'b1, 1'b0);
        tick(1); sweep_start = 1'b0;
        tick(6);

        // Asynchronous reset in the middle of a dwell.
        c = cyc;
        start_sweep(32'd7000, 32'd1, 16'd4, 16'd10);
        expect_event(c + 2, 32'd7000, 12'h456, 1'b0, 1'b0, 1'b1);
        tick(1); sweep_start = 1'b0;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_fword", fword, 32'h0);
        check_output("midreset_pword", {20'h0, pword}, 32'h0);
        check_output("midreset_ack", {31'h0, host_ack}, 32'h0);
        check_output("midreset_done", {31'h0, sweep_done}, 32'h0);
        check_output("midreset_busy", {31'h0, busy}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check_output("post_reset_fword", fword, 32'h0);
        check_output("post_reset_busy", {31'h0, busy}, 32'h0);
        wrap = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
        while (exp_q.size() > 0) begin
            left_e = exp_q.pop_front();
            total_cnt++;
            $display("[TB] FAIL missing_event: got nothing, want cyc=%0d f=%h p=%h ack=%b done=%b",
                     left_e.cyc, left_e.f, left_e.p, left_e.ack, left_e.done);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
